// File: rtl/ps2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// ps2_pkg : state encoding and constants shared by the PS/2 host TX
// Rev 1.0
// ----------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // data bits, parity and stop are each launched on their own falling edge
  localparam logic [3:0] FRAME_EDGES = 4'd10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ----------------------------------------------------------------
// ps2_sync : 2-flop pad synchronizer with falling-edge detect
// Rev 1.0
// ----------------------------------------------------------------
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  output logic level,
  output logic fall
);
  import ps2_pkg::*;

  logic meta;
  logic sync;
  logic prev;

  // idle PS/2 lines are pulled high, so all stages reset to 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pad_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ----------------------------------------------------------------
// ps2_host_tx : PS/2 host-to-device command transmitter
// Option macro PS2_HOST_TX_RETRY_EN adds one automatic retry. Rev 1.0
// ----------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import ps2_pkg::*;

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync u_sync_clk (
    .clk    (clk),
    .rst    (rst),
    .pad_in (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_sync u_sync_data (
    .clk    (clk),
    .rst    (rst),
    .pad_in (ps2_data_in),
    .level  (data_level),
    .fall   (data_fall_unused)
  );

  ps2_state_t       state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [3:0]       edge_cnt, edge_cnt_n;
  logic [7:0]       data_q, data_n;
  logic             par_q, par_n;
  logic             clk_oe_n, data_oe_n, done_n, err_n;
  logic             tmo_hit, fail, restart;
`ifdef PS2_HOST_TX_RETRY_EN
  logic             retried, retried_n;
`endif

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;

  always_comb begin
    state_n    = state;
    inh_cnt_n  = inh_cnt;
    tmo_cnt_n  = tmo_cnt;
    edge_cnt_n = edge_cnt;
    data_n     = data_q;
    par_n      = par_q;
    clk_oe_n   = ps2_clk_oe;
    data_oe_n  = ps2_data_oe;
    done_n     = 1'b0;
    err_n      = 1'b0;
    fail       = 1'b0;
    restart    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retried_n  = retried;
`endif

    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          data_n  = tx_data;
          par_n   = odd_parity(tx_data);
          restart = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
          retried_n = 1'b0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_n    = ST_REQ;
          clk_oe_n   = 1'b0;
          data_oe_n  = 1'b1;
          tmo_cnt_n  = '0;
          edge_cnt_n = '0;
        end else begin
          inh_cnt_n = inh_cnt + INH_W'(1);
        end
      end
      ST_REQ, ST_SHIFT: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
          if (clk_fall) begin
            edge_cnt_n = edge_cnt + 4'd1;
            if (edge_cnt < 4'd8)
              data_oe_n = ~data_q[edge_cnt[2:0]];
            else if (edge_cnt == 4'd8)
              data_oe_n = ~par_q;
            else
              data_oe_n = 1'b0;
            state_n = (edge_cnt_n == FRAME_EDGES) ? ST_ACK : ST_SHIFT;
          end
        end
      end
      ST_ACK: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
          if (clk_fall) begin
            if (!data_level)
              state_n = ST_RELEASE;
            else
              fail = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
          if (clk_level && data_level) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n   = ST_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase

    // failures free both lines first; a retry then re-inhibits the bus
    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retried) begin
        retried_n = 1'b1;
        restart   = 1'b1;
      end else begin
        err_n   = 1'b1;
        state_n = ST_IDLE;
      end
`else
      err_n   = 1'b1;
      state_n = ST_IDLE;
`endif
    end

    if (restart) begin
      state_n   = ST_INHIBIT;
      clk_oe_n  = 1'b1;
      data_oe_n = 1'b0;
      inh_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      edge_cnt    <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      edge_cnt    <= edge_cnt_n;
      data_q      <= data_n;
      par_q       <= par_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      err         <= err_n;
`ifdef PS2_HOST_TX_RETRY_EN
      retried     <= retried_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_ps2_host_tx : open-drain bus + PS/2 device model, frame scoreboard
// Rev 1.0
// ----------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 200;
  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ndone = 0, nerr = 0, ninh = 0;
  int inh_run = 0, last_inh = 0;
  int req_cyc = 0, err_cyc = 0;
  logic [1:0] err_oe = 2'b00;
  logic prev_clk_oe = 1'b0;
  logic [7:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Continuous invariants plus event bookkeeping for the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check("ready_vs_busy", tx_ready, !busy);
      check("done_err_excl", done & err, 0);
      if (!busy) check("idle_lines", {ps2_clk_oe, ps2_data_oe}, 0);
      if (ps2_clk_oe) check("inhibit_data", ps2_data_oe, 0);
      if (tx_valid && tx_ready) acc_q.push_back(tx_data);
      if (done) ndone++;
      if (err) begin
        nerr++;
        err_cyc = cyc;
        err_oe = {ps2_clk_oe, ps2_data_oe};
      end
    end
    if (ps2_clk_oe && !prev_clk_oe) ninh++;
    if (prev_clk_oe && !ps2_clk_oe && ps2_data_oe) req_cyc = cyc;
    if (ps2_clk_oe) inh_run++;
    else if (inh_run > 0) begin
      last_inh = inh_run;
      inh_run = 0;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  // Expected frame as the device sees it: start, LSB-first data, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy) ok = 1;
    end
  endtask

  task automatic wait_end(input int d0, input int e0, input int lim, input string name);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(posedge clk); #1;
      if (ndone > d0 || nerr > e0) seen = 1;
    end
    if (!seen) bound_fail(name);
  endtask

  task automatic pop_acc(input logic [7:0] b, input string name);
    if (acc_q.size() == 0) bound_fail(name);
    else check(name, acc_q.pop_front(), b);
  endtask

  task automatic device_frame(input bit ack, input int npulse, input int half,
                              output logic [10:0] bits);
    bit seen = 0;
    bits = '0;
    for (int i = 0; i < 2 * INH + 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (!ps2_clk_oe && ps2_data_oe) seen = 1;
    end
    if (!seen) begin
      bound_fail("device_req_wait");
      return;
    end
    repeat (10) @(posedge clk);
    #1;
    bits[0] = ps2_data_line;
    for (int k = 1; k <= npulse; k++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(posedge clk);
      #1;
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps2_data_line;
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  task automatic txn(input logic [7:0] b, input bit a1, input bit a2, input int half,
                     output logic [10:0] bits);
    int d0, e0, i0, exp_inh;
    bit ok, exp_done;
    d0 = ndone; e0 = nerr; i0 = ninh;
    exp_done = a1;
    exp_inh = 1;
    tx_data = b;
    tx_valid = 1'b1;
    wait_busy(ok);
    tx_valid = 1'b0;
    if (!ok) bound_fail("accept");
    device_frame(a1, 11, half, bits);
    check("frame", bits, frame_of(b));
`ifdef PS2_HOST_TX_RETRY_EN
    if (!a1) begin
      device_frame(a2, 11, half, bits);
      check("retry_frame", bits, frame_of(b));
      exp_done = a2;
      exp_inh = 2;
    end
`else
    if (a2) exp_inh = 1;
`endif
    wait_end(d0, e0, TMO, "frame_end");
    repeat (3) @(posedge clk);
    #1;
    check("done_count", ndone - d0, exp_done);
    check("err_count", nerr - e0, !exp_done);
    check("inhibit_phases", ninh - i0, exp_inh);
    check("inhibit_len", last_inh, INH);
    check("ready_after", tx_ready, 1);
    pop_acc(b, "accepted_byte");
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0;
    bit ok;

    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    txn(CMD_SET_LED, 1'b1, 1'b1, 30, bits);
    check("led_frame_literal", bits, 11'h7DA);

    txn(8'h00, 1'b0, 1'b0, 30, bits);
    check("zero_frame_literal", bits, 11'h600);

    // device never clocks
    d0 = ndone; e0 = nerr;
    tx_data = CMD_RESET;
    tx_valid = 1'b1;
    wait_busy(ok);
    tx_valid = 1'b0;
    wait_end(d0, e0, 2 * (TMO + INH) + 200, "timeout_wait");
    check("timeout_latency", err_cyc - req_cyc, TMO);
    check("timeout_lines", err_oe, 0);
    check("timeout_no_done", ndone - d0, 0);
    pop_acc(CMD_RESET, "timeout_accept");
    repeat (5) @(posedge clk);
    #1;

    // reset after falling edge 4
    tx_data = CMD_RESET;
    tx_valid = 1'b1;
    wait_busy(ok);
    tx_valid = 1'b0;
    device_frame(1'b0, 4, 30, bits);
    check("partial_bits", bits[4:0], 5'b11110);
    d0 = ndone; e0 = nerr;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_pulses", {done, err}, 0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_no_events", (ndone - d0) + (nerr - e0), 0);
    pop_acc(CMD_RESET, "rst_mid_accept");

    // reset while inhibiting
    tx_data = CMD_ENABLE;
    tx_valid = 1'b1;
    wait_busy(ok);
    tx_valid = 1'b0;
    repeat (INH / 2) @(posedge clk);
    #1;
    check("inhibit_active", ps2_clk_oe, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_inh_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_inh_no_events", (ndone - d0) + (nerr - e0), 0);
    pop_acc(CMD_ENABLE, "rst_inh_accept");

    // tx_valid held across a whole frame
    d0 = ndone; e0 = nerr;
    tx_data = CMD_ENABLE;
    tx_valid = 1'b1;
    fork
      device_frame(1'b1, 11, 30, bits);
      begin
        wait_busy(ok);
        tx_data = 8'h55;
      end
    join
    check("held_frame_literal", bits, 11'h5E8);
    wait_end(d0, e0, TMO, "held_first_end");
    wait_busy(ok);
    tx_valid = 1'b0;
    device_frame(1'b1, 11, 30, bits);
    check("held_second_literal", bits, 11'h6AA);
    repeat (10) @(posedge clk);
    #1;
    check("held_done_count", ndone - d0, 2);
    check("held_err_count", nerr - e0, 0);
    pop_acc(CMD_ENABLE, "held_accept_0");
    pop_acc(8'h55, "held_accept_1");
    check("held_accept_total", acc_q.size(), 0);

`ifdef PS2_HOST_TX_RETRY_EN
    txn(CMD_ENABLE, 1'b0, 1'b1, 30, bits);
    check("retry_frame_literal", bits, 11'h5E8);
`endif

    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      bit a1, a2;
      int half;
      b = 8'($urandom);
      a1 = ($urandom_range(0, 3) != 0);
      a2 = 1'($urandom_range(0, 1));
      half = $urandom_range(20, 45);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      txn(b, a1, a2, half, bits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
